// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory responder slice.
//   DEPTH_WORDS_DEFAULT : default number of 32-bit words in the memory
//   BE_B0..BE_B3        : single-byte lane-enable patterns
//   BE_H0, BE_H1        : half-word lane-enable patterns (low / high half)
//   BE_W                : full-word lane-enable pattern
//   dmem_rsp_t          : response record {rdata[31:0], err}
//   be_legal()          : byte-enable pattern vs. address-alignment check
// ---------------------------------------------------------------------------
package dmem_pkg;

  localparam int DEPTH_WORDS_DEFAULT = 4096;

  localparam logic [3:0] BE_B0 = 4'b0001;
  localparam logic [3:0] BE_B1 = 4'b0010;
  localparam logic [3:0] BE_B2 = 4'b0100;
  localparam logic [3:0] BE_B3 = 4'b1000;
  localparam logic [3:0] BE_H0 = 4'b0011;
  localparam logic [3:0] BE_H1 = 4'b1100;
  localparam logic [3:0] BE_W  = 4'b1111;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } dmem_rsp_t;

  // A lane pattern is only legal when it is one of the seven supported
  // shapes and it sits on the lanes selected by the low address bits.
  function automatic logic be_legal(input logic [3:0] be, input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    case (be)
      BE_B0:   ok = (addr_lo == 2'b00);
      BE_B1:   ok = (addr_lo == 2'b01);
      BE_B2:   ok = (addr_lo == 2'b10);
      BE_B3:   ok = (addr_lo == 2'b11);
      BE_H0:   ok = (addr_lo == 2'b00);
      BE_H1:   ok = (addr_lo == 2'b10);
      BE_W:    ok = (addr_lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_rsp_fifo.sv
// ---------------------------------------------------------------------------
// dmem_rsp_fifo
// Two-entry synchronous FIFO of response records.
//   clk       : clock, all updates on the rising edge
//   rst_n     : synchronous active-low reset, empties the FIFO
//   push      : write push_data at the tail (ignored when full unless popping)
//   push_data : response record to enqueue
//   pop       : drop the head entry (ignored when empty)
//   head      : current head record (meaningful only when count != 0)
//   count     : number of stored entries, 0..2
// ---------------------------------------------------------------------------
module dmem_rsp_fifo
  import dmem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  dmem_rsp_t  push_data,
  input  logic       pop,
  output dmem_rsp_t  head,
  output logic [1:0] count
);

  dmem_rsp_t  entries_q [2];
  dmem_rsp_t  entries_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       do_push, do_pop;

  // A pop on an empty FIFO is ignored so that a simultaneous push is kept.
  // A push on a full FIFO is only taken when the head leaves in the same
  // cycle; the freed slot is the one the write pointer already points at.
  always_comb begin
    do_pop    = pop && (count_q != 2'd0);
    do_push   = push && ((count_q != 2'd2) || do_pop);
    entries_d = entries_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (do_push) begin
      entries_d[wr_ptr_q] = push_data;
      wr_ptr_d            = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + 2'(do_push) - 2'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: an entry is never read before written.
  always_ff @(posedge clk) begin
    entries_q <= entries_d;
  end

  assign head  = entries_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Word-organised data memory with byte-lane writes behind a valid/ready
// request channel and a valid/ready response channel. Illegal requests
// (bad lane pattern, misaligned lanes, word index out of range) get an
// error response and have no memory side effect.
//   clk         : clock
//   rst_n       : synchronous active-low reset (memory contents are kept)
//   req_valid   : request present
//   req_ready   : request accepted this cycle
//   req_addr    : byte address, bits [ADDR_W-1:2] select the word
//   req_we      : 1 = store, 0 = load
//   req_byteena : byte lane enables
//   req_wdata   : store data, already lane-replicated
//   rsp_valid   : response available
//   rsp_ready   : response consumed this cycle
//   rsp_rdata   : full stored word for legal loads, 0 otherwise
//   rsp_err     : request was illegal
// ---------------------------------------------------------------------------
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEFAULT,
  parameter int ADDR_W      = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_we,
  input  logic [3:0]        req_byteena,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [31:0]      mem_q [DEPTH_WORDS];
  logic [31:0]      rd_data_q;

  logic [31:0]      word_idx;
  logic [IDX_W-1:0] ram_idx;
  logic             in_range;
  logic             legal;
  logic             accept;
  logic             do_write;
  logic             do_read;
  logic             pop;
  logic [2:0]       occupancy;

  logic             in_flight_q, in_flight_d;
  logic             in_flight_load_q, in_flight_load_d;
  logic             in_flight_err_q, in_flight_err_d;

  logic [1:0]       fifo_count;
  dmem_rsp_t        fifo_head;
  dmem_rsp_t        push_rec;

  // Decode and legality. The word index is widened so that the range check
  // works even when the address can reach beyond the memory depth.
  always_comb begin
    word_idx = 32'(req_addr[ADDR_W-1:2]);
    ram_idx  = word_idx[IDX_W-1:0];
    in_range = (word_idx < 32'(DEPTH_WORDS));
    legal    = in_range && be_legal(req_byteena, req_addr[1:0]);
  end

  // Occupancy counts stored responses plus the one whose read is still in
  // flight, minus a head leaving this cycle; two slots exist in total, so a
  // new request fits only while fewer than two are claimed. Reset forces
  // ready low so nothing can be accepted or written while rst_n is low.
  always_comb begin
    pop       = rsp_valid && rsp_ready;
    occupancy = {1'b0, fifo_count} + {2'b00, in_flight_q} - {2'b00, pop};
    req_ready = rst_n && (occupancy < 3'd2);
    accept    = req_valid && req_ready;
    do_write  = accept && legal && req_we;
    do_read   = accept && legal && !req_we;
  end

  // Single-port word RAM with per-byte write enables and a registered read.
  // A store and a load never share an edge, and a load one edge after a
  // store sees the updated word without any bypass path.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (req_byteena[lane]) begin
          mem_q[ram_idx][lane*8 +: 8] <= req_wdata[lane*8 +: 8];
        end
      end
    end
    if (do_read) begin
      rd_data_q <= mem_q[ram_idx];
    end
  end

  // The in-flight stage remembers what kind of response the accepted
  // request owes, so it can be formed once the RAM read data is available.
  always_comb begin
    in_flight_d      = accept;
    in_flight_load_d = do_read;
    in_flight_err_d  = accept && !legal;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_flight_q      <= 1'b0;
      in_flight_load_q <= 1'b0;
      in_flight_err_q  <= 1'b0;
    end else begin
      in_flight_q      <= in_flight_d;
      in_flight_load_q <= in_flight_load_d;
      in_flight_err_q  <= in_flight_err_d;
    end
  end

  // Stores and errors return zero data; only legal loads carry the word.
  always_comb begin
    push_rec.rdata = in_flight_load_q ? rd_data_q : 32'h0;
    push_rec.err   = in_flight_err_q;
  end

  dmem_rsp_fifo u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_flight_q),
    .push_data (push_rec),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  // Outputs are forced to zero when nothing is queued so that stale payload
  // from a previous entry is never visible.
  always_comb begin
    rsp_valid = (fifo_count != 2'd0);
    rsp_rdata = rsp_valid ? fifo_head.rdata : 32'h0;
    rsp_err   = rsp_valid && fifo_head.err;
  end

endmodule
